// File: rtl/tetris_pkg.sv
// Shared board constants, colour type and fetch-FSM encoding for the cell row scaler.
package tetris_pkg;

    localparam int COLS_DEF = 12;
    localparam int ROWS_DEF = 22;
    localparam int CW_DEF   = 4;

    typedef logic [CW_DEF-1:0] cell_color_t;

    localparam cell_color_t BG_COLOR_DEF   = 4'd0;
    localparam cell_color_t GRID_COLOR_DEF = 4'd15;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_READY = 2'd2
    } fetch_state_t;

    // Index width for a counter over n values, never below one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cell_line_buffer.sv
// Double buffer for one board row: back half filled by the fetch, front half read by the pixel path.
module cell_line_buffer
    import tetris_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int CW   = CW_DEF,
    parameter int CLW  = clog2_min1(COLS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [COLS*CW-1:0]   wr_data,
    input  logic                 load_en,
    input  logic [CLW-1:0]       rd_col,
    output logic [CW-1:0]        rd_color
);

    logic [COLS*CW-1:0] back_r;
    logic [COLS*CW-1:0] front_r;

    // Capture fetched row into the back half; promote it to the front half on a row swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            back_r  <= '0;
            front_r <= '0;
        end else begin
            if (wr_en) begin
                back_r <= wr_data;
            end else begin
                back_r <= back_r;
            end
            if (load_en) begin
                front_r <= back_r;
            end else begin
                front_r <= front_r;
            end
        end
    end

    assign rd_color = front_r[rd_col*CW +: CW];

endmodule

// File: rtl/cell_row_scaler.sv
// Upscales a board of colour cells onto a raster: tracks line/pixel position with counters,
// prefetches the next cell row one line ahead and produces one colour per active pixel.
module cell_row_scaler
    import tetris_pkg::*;
#(
    parameter int COLS       = COLS_DEF,
    parameter int ROWS       = ROWS_DEF,
    parameter int SCALE      = 20,
    parameter int CW         = CW_DEF,
    parameter int X_OFF      = 0,
    parameter int Y_OFF      = 1,
    parameter int BG_COLOR   = int'(BG_COLOR_DEF),
    parameter int GRID_COLOR = int'(GRID_COLOR_DEF)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_start,
    input  logic                      line_start,
    input  logic                      pix_valid,
    input  logic                      grid_en,
    output logic                      rd_req,
    output logic [$clog2(ROWS)-1:0]   rd_row,
    input  logic                      rd_ack,
    input  logic [COLS*CW-1:0]        rd_data,
    output logic [CW-1:0]             pix_color,
    output logic                      pix_out_valid,
    output logic                      underrun
);

    localparam int RW       = $clog2(ROWS);
    localparam int CLW      = clog2_min1(COLS);
    localparam int SW       = clog2_min1(SCALE);
    localparam int LINE_MAX = Y_OFF + ROWS * SCALE + 1;
    localparam int LW       = $clog2(LINE_MAX + 1);
    localparam int X_MAX    = X_OFF + COLS * SCALE + 1;
    localparam int XW       = $clog2(X_MAX + 1);

    localparam logic [CW-1:0] BG_C   = CW'(BG_COLOR);
    localparam logic [CW-1:0] GRID_C = CW'(GRID_COLOR);

    // Vertical position of the current line
    logic [LW-1:0]  line_r;
    logic           first_pending_r;
    logic           in_y_r;
    logic [RW-1:0]  row_r;
    logic [SW-1:0]  sub_row_r;

    // Horizontal position of the next pixel
    logic [XW-1:0]  x_r;
    logic           in_x_r;
    logic [CLW-1:0] col_r;
    logic [SW-1:0]  sub_col_r;

    fetch_state_t   state_r;
    fetch_state_t   state_eff_s;

    logic [LW-1:0]  new_line_s;
    logic           y_in_s;
    logic           nin_y_s;
    logic [RW-1:0]  nrow_s;
    logic [SW-1:0]  nsub_row_s;
    logic           swap_s;
    logic           fetch_s;
    logic [RW-1:0]  fetch_row_s;

    logic [XW-1:0]  nx_s;
    logic           nin_x_s;
    logic [CLW-1:0] ncol_s;
    logic [SW-1:0]  nsub_col_s;

    logic           capture_s;
    logic           load_s;
    logic           swap_fail_s;
    logic [CW-1:0]  buf_color_s;
    logic [CW-1:0]  pixel_s;

    // Position of the line announced by line_start and whether it starts or precedes a cell row.
    always_comb begin
        if (frame_start || first_pending_r) begin
            new_line_s = '0;
        end else if (line_r == LW'(LINE_MAX)) begin
            new_line_s = line_r;
        end else begin
            new_line_s = line_r + LW'(1);
        end

        y_in_s      = in_y_r & ~frame_start;
        nin_y_s     = y_in_s;
        nrow_s      = row_r;
        nsub_row_s  = sub_row_r;
        swap_s      = 1'b0;
        fetch_s     = 1'b0;
        fetch_row_s = '0;

        if (new_line_s == LW'(Y_OFF)) begin
            nin_y_s    = 1'b1;
            nrow_s     = '0;
            nsub_row_s = '0;
            swap_s     = 1'b1;
        end else if (y_in_s) begin
            if (sub_row_r == SW'(SCALE - 1)) begin
                if (row_r == RW'(ROWS - 1)) begin
                    nin_y_s = 1'b0;
                end else begin
                    nrow_s     = row_r + RW'(1);
                    nsub_row_s = '0;
                    swap_s     = 1'b1;
                end
            end else begin
                nsub_row_s = sub_row_r + SW'(1);
            end
        end else begin
            nin_y_s = 1'b0;
        end

        // The row needed on the next line is requested one line early.
        if (new_line_s == LW'(Y_OFF - 1)) begin
            fetch_s     = 1'b1;
            fetch_row_s = '0;
        end else if (nin_y_s && (nsub_row_s == SW'(SCALE - 1)) && (nrow_s != RW'(ROWS - 1))) begin
            fetch_s     = 1'b1;
            fetch_row_s = nrow_s + RW'(1);
        end else begin
            fetch_s     = 1'b0;
            fetch_row_s = '0;
        end
    end

    // Line and cell-row counters, restarted by frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_r          <= '0;
            first_pending_r <= 1'b1;
            in_y_r          <= 1'b0;
            row_r           <= '0;
            sub_row_r       <= '0;
        end else if (line_start) begin
            line_r          <= new_line_s;
            first_pending_r <= 1'b0;
            in_y_r          <= nin_y_s;
            row_r           <= nrow_s;
            sub_row_r       <= nsub_row_s;
        end else if (frame_start) begin
            line_r          <= '0;
            first_pending_r <= 1'b1;
            in_y_r          <= 1'b0;
            row_r           <= row_r;
            sub_row_r       <= sub_row_r;
        end else begin
            line_r          <= line_r;
            first_pending_r <= first_pending_r;
            in_y_r          <= in_y_r;
            row_r           <= row_r;
            sub_row_r       <= sub_row_r;
        end
    end

    // Horizontal position after the current pixel strobe.
    always_comb begin
        if (x_r == XW'(X_MAX)) begin
            nx_s = x_r;
        end else begin
            nx_s = x_r + XW'(1);
        end
        nin_x_s    = in_x_r;
        ncol_s     = col_r;
        nsub_col_s = sub_col_r;
        if (nx_s == XW'(X_OFF)) begin
            nin_x_s    = 1'b1;
            ncol_s     = '0;
            nsub_col_s = '0;
        end else if (in_x_r) begin
            if (sub_col_r == SW'(SCALE - 1)) begin
                if (col_r == CLW'(COLS - 1)) begin
                    nin_x_s = 1'b0;
                end else begin
                    ncol_s     = col_r + CLW'(1);
                    nsub_col_s = '0;
                end
            end else begin
                nsub_col_s = sub_col_r + SW'(1);
            end
        end else begin
            nin_x_s = 1'b0;
        end
    end

    // Pixel and cell-column counters, restarted at every line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r       <= '0;
            in_x_r    <= (X_OFF == 0);
            col_r     <= '0;
            sub_col_r <= '0;
        end else if (line_start) begin
            x_r       <= '0;
            in_x_r    <= (X_OFF == 0);
            col_r     <= '0;
            sub_col_r <= '0;
        end else if (pix_valid) begin
            x_r       <= nx_s;
            in_x_r    <= nin_x_s;
            col_r     <= ncol_s;
            sub_col_r <= nsub_col_s;
        end else begin
            x_r       <= x_r;
            in_x_r    <= in_x_r;
            col_r     <= col_r;
            sub_col_r <= sub_col_r;
        end
    end

    // frame_start acts before anything else, so the FSM behaves as if already idle that cycle.
    always_comb begin
        if (frame_start) begin
            state_eff_s = FETCH_IDLE;
        end else begin
            state_eff_s = state_r;
        end
        capture_s   = (state_eff_s == FETCH_REQ) && rd_ack;
        load_s      = line_start && swap_s && (state_eff_s == FETCH_READY);
        swap_fail_s = line_start && swap_s && (state_eff_s != FETCH_READY);
    end

    // Row fetch FSM with its request outputs and the sticky underrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= FETCH_IDLE;
            rd_req   <= 1'b0;
            rd_row   <= '0;
            underrun <= 1'b0;
        end else begin
            case (state_eff_s)
                FETCH_IDLE: begin
                    if (line_start && fetch_s) begin
                        state_r <= FETCH_REQ;
                        rd_req  <= 1'b1;
                        rd_row  <= fetch_row_s;
                    end else begin
                        state_r <= FETCH_IDLE;
                        rd_req  <= 1'b0;
                    end
                end
                FETCH_REQ: begin
                    if (rd_ack) begin
                        state_r <= FETCH_READY;
                        rd_req  <= 1'b0;
                    end else begin
                        state_r <= FETCH_REQ;
                        rd_req  <= 1'b1;
                    end
                end
                FETCH_READY: begin
                    rd_req <= 1'b0;
                    if (load_s) begin
                        state_r <= FETCH_IDLE;
                    end else begin
                        state_r <= FETCH_READY;
                    end
                end
                default: begin
                    state_r <= FETCH_IDLE;
                    rd_req  <= 1'b0;
                end
            endcase

            if (frame_start) begin
                underrun <= swap_fail_s;
            end else if (swap_fail_s) begin
                underrun <= 1'b1;
            end else begin
                underrun <= underrun;
            end
        end
    end

    cell_line_buffer #(
        .COLS (COLS),
        .CW   (CW),
        .CLW  (CLW)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (capture_s),
        .wr_data  (rd_data),
        .load_en  (load_s),
        .rd_col   (col_r),
        .rd_color (buf_color_s)
    );

    // Colour of the pixel being strobed this cycle.
    always_comb begin
        if (!(in_x_r && in_y_r)) begin
            pixel_s = BG_C;
        end else if (grid_en && ((sub_col_r == '0) || (sub_row_r == '0))) begin
            pixel_s = GRID_C;
        end else begin
            pixel_s = buf_color_s;
        end
    end

    // One-cycle output stage; colour holds between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_color     <= '0;
            pix_out_valid <= 1'b0;
        end else begin
            pix_out_valid <= pix_valid;
            if (pix_valid) begin
                pix_color <= pixel_s;
            end else begin
                pix_color <= pix_color;
            end
        end
    end

endmodule

// File: tb/tb_cell_row_scaler.sv
// Directed bench: default-parameter instance plus a COLS=10/SCALE=16/CW=3 instance on shared timing inputs.
module tb_cell_row_scaler;

    logic clk;
    logic rst_n;
    logic frame_start;
    logic line_start;
    logic pix_valid;
    logic grid_en;

    logic        rd_req1;
    logic [4:0]  rd_row1;
    logic        resp_ack1;
    logic        stray_ack1;
    logic        rd_ack1;
    logic [47:0] resp_data1;
    logic [47:0] stray_data1;
    logic [47:0] rd_data1;
    logic [3:0]  pix_color1;
    logic        pix_out_valid1;
    logic        underrun1;
    logic        ack_en1;

    logic        rd_req2;
    logic [4:0]  rd_row2;
    logic        rd_ack2;
    logic [29:0] rd_data2;
    logic [2:0]  pix_color2;
    logic        pix_out_valid2;
    logic        underrun2;

    logic [3:0]  col1 [0:255];
    logic        v1   [0:255];
    logic [2:0]  col2 [0:255];
    logic        v2   [0:255];
    logic [3:0]  hold_color1;
    logic        hold_valid1;

    int tests;
    int fails;

    assign rd_ack1  = resp_ack1 | stray_ack1;
    assign rd_data1 = stray_ack1 ? stray_data1 : resp_data1;

    cell_row_scaler dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .line_start    (line_start),
        .pix_valid     (pix_valid),
        .grid_en       (grid_en),
        .rd_req        (rd_req1),
        .rd_row        (rd_row1),
        .rd_ack        (rd_ack1),
        .rd_data       (rd_data1),
        .pix_color     (pix_color1),
        .pix_out_valid (pix_out_valid1),
        .underrun      (underrun1)
    );

    cell_row_scaler #(.COLS(10), .SCALE(16), .CW(3)) dut2 (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .line_start    (line_start),
        .pix_valid     (pix_valid),
        .grid_en       (1'b0),
        .rd_req        (rd_req2),
        .rd_row        (rd_row2),
        .rd_ack        (rd_ack2),
        .rd_data       (rd_data2),
        .pix_color     (pix_color2),
        .pix_out_valid (pix_out_valid2),
        .underrun      (underrun2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] color1(input int r);
        if (r == 0) return 4'd3;
        else if (r == 5) return 4'd7;
        else return 4'(r % 16);
    endfunction

    function automatic logic [47:0] pack1(input logic [4:0] r);
        logic [47:0] d;
        d = '0;
        for (int c = 0; c < 12; c++) d[c*4 +: 4] = color1(int'(r));
        return d;
    endfunction

    function automatic logic [29:0] pack2(input logic [4:0] r);
        logic [29:0] d;
        d = '0;
        for (int c = 0; c < 10; c++) d[c*3 +: 3] = 3'((int'(r) + c) % 8);
        return d;
    endfunction

    // Memory model for the default instance: acks two cycles after the request when enabled.
    initial begin
        int cnt1;
        cnt1 = 0;
        resp_ack1 = 1'b0;
        resp_data1 = '0;
        forever begin
            @(negedge clk);
            resp_ack1 = 1'b0;
            if (ack_en1 && rd_req1 && rst_n) begin
                cnt1++;
                if (cnt1 >= 2) begin
                    resp_ack1 = 1'b1;
                    resp_data1 = pack1(rd_row1);
                    cnt1 = 0;
                end
            end else begin
                cnt1 = 0;
            end
        end
    end

    // Memory model for the reduced instance, always answering.
    initial begin
        int cnt2;
        cnt2 = 0;
        rd_ack2 = 1'b0;
        rd_data2 = '0;
        forever begin
            @(negedge clk);
            rd_ack2 = 1'b0;
            if (rd_req2 && rst_n) begin
                cnt2++;
                if (cnt2 >= 2) begin
                    rd_ack2 = 1'b1;
                    rd_data2 = pack2(rd_row2);
                    cnt2 = 0;
                end
            end else begin
                cnt2 = 0;
            end
        end
    end

    task automatic do_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic do_line(input int npix);
        @(negedge clk);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        @(negedge clk);
        for (int x = 0; x < npix; x++) begin
            pix_valid = 1'b1;
            @(negedge clk);
            col1[x] = pix_color1;
            v1[x]   = pix_out_valid1;
            col2[x] = pix_color2;
            v2[x]   = pix_out_valid2;
        end
        pix_valid = 1'b0;
        @(negedge clk);
        hold_color1 = pix_color1;
        hold_valid1 = pix_out_valid1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (rd_req1 !== 1'b0) begin fails++; $display("FAIL reset_rd_req: got %0b expected 0", rd_req1); end
        tests++; if (rd_row1 !== 5'd0) begin fails++; $display("FAIL reset_rd_row: got %0d expected 0", rd_row1); end
        tests++; if (pix_color1 !== 4'd0) begin fails++; $display("FAIL reset_pix_color: got %0d expected 0", pix_color1); end
        tests++; if (pix_out_valid1 !== 1'b0) begin fails++; $display("FAIL reset_pix_out_valid: got %0b expected 0", pix_out_valid1); end
        tests++; if (underrun1 !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %0b expected 0", underrun1); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int bad;
        grid_en = 1'b0;
        ack_en1 = 1'b0;
        do_frame();
        do_line(0);
        tests++; if (rd_req1 !== 1'b1) begin fails++; $display("FAIL basic_req_line0: got %0b expected 1", rd_req1); end
        tests++; if (rd_row1 !== 5'd0) begin fails++; $display("FAIL basic_row_line0: got %0d expected 0", rd_row1); end
        ack_en1 = 1'b1;
        repeat (4) @(negedge clk);
        tests++; if (rd_req1 !== 1'b0) begin fails++; $display("FAIL basic_req_after_ack: got %0b expected 0", rd_req1); end
        do_line(241);
        bad = 0;
        for (int x = 0; x < 240; x++) if (col1[x] !== 4'd3) bad++;
        tests++; if (bad !== 0) begin fails++; $display("FAIL basic_line1_board: %0d pixels wrong, col[0]=%0d expected 3", bad, col1[0]); end
        tests++; if (col1[239] !== 4'd3) begin fails++; $display("FAIL basic_x239: got %0d expected 3", col1[239]); end
        tests++; if (col1[240] !== 4'd0) begin fails++; $display("FAIL basic_x240_bg: got %0d expected 0", col1[240]); end
        tests++; if (v1[0] !== 1'b1) begin fails++; $display("FAIL basic_latency_valid: got %0b expected 1", v1[0]); end
        tests++; if (underrun1 !== 1'b0) begin fails++; $display("FAIL basic_underrun: got %0b expected 0", underrun1); end
        do_line(10);
        tests++; if (hold_color1 !== 4'd3) begin fails++; $display("FAIL basic_hold_color: got %0d expected 3", hold_color1); end
        tests++; if (hold_valid1 !== 1'b0) begin fails++; $display("FAIL basic_hold_valid: got %0b expected 0", hold_valid1); end
    endtask

    task automatic test_grid();
        int bad;
        for (int l = 3; l <= 100; l++) do_line(0);
        grid_en = 1'b1;
        do_line(241);
        bad = 0;
        for (int x = 0; x < 240; x++) if (col1[x] !== 4'd15) bad++;
        tests++; if (bad !== 0) begin fails++; $display("FAIL grid_line101: %0d pixels wrong, col[1]=%0d expected 15", bad, col1[1]); end
        tests++; if (col1[240] !== 4'd0) begin fails++; $display("FAIL grid_line101_bg: got %0d expected 0", col1[240]); end
        do_line(241);
        tests++; if (col1[0] !== 4'd15) begin fails++; $display("FAIL grid_x0: got %0d expected 15", col1[0]); end
        tests++; if (col1[19] !== 4'd7) begin fails++; $display("FAIL grid_x19: got %0d expected 7", col1[19]); end
        tests++; if (col1[20] !== 4'd15) begin fails++; $display("FAIL grid_x20: got %0d expected 15", col1[20]); end
        tests++; if (col1[21] !== 4'd7) begin fails++; $display("FAIL grid_x21: got %0d expected 7", col1[21]); end
        tests++; if (col1[240] !== 4'd0) begin fails++; $display("FAIL grid_x240_bg: got %0d expected 0", col1[240]); end
        grid_en = 1'b0;
    endtask

    task automatic test_underrun();
        ack_en1 = 1'b1;
        do_frame();
        for (int l = 0; l < 40; l++) do_line(0);
        ack_en1 = 1'b0;
        do_line(0);
        tests++; if (rd_req1 !== 1'b1) begin fails++; $display("FAIL under_req_row2: got %0b expected 1", rd_req1); end
        tests++; if (rd_row1 !== 5'd2) begin fails++; $display("FAIL under_row2: got %0d expected 2", rd_row1); end
        do_line(241);
        tests++; if (underrun1 !== 1'b1) begin fails++; $display("FAIL under_flag: got %0b expected 1", underrun1); end
        tests++; if (col1[0] !== 4'd1) begin fails++; $display("FAIL under_repeat_x0: got %0d expected 1", col1[0]); end
        tests++; if (col1[239] !== 4'd1) begin fails++; $display("FAIL under_repeat_x239: got %0d expected 1", col1[239]); end
        tests++; if (rd_req1 !== 1'b1) begin fails++; $display("FAIL under_req_held: got %0b expected 1", rd_req1); end
        do_frame();
        tests++; if (underrun1 !== 1'b0) begin fails++; $display("FAIL under_cleared: got %0b expected 0", underrun1); end
        tests++; if (rd_req1 !== 1'b0) begin fails++; $display("FAIL under_frame_idle: got %0b expected 0", rd_req1); end
        ack_en1 = 1'b1;
    endtask

    task automatic test_reset_mid_fetch();
        ack_en1 = 1'b0;
        do_frame();
        do_line(0);
        tests++; if (rd_req1 !== 1'b1) begin fails++; $display("FAIL rst_pre_req: got %0b expected 1", rd_req1); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++; if (rd_req1 !== 1'b0) begin fails++; $display("FAIL rst_async_req: got %0b expected 0", rd_req1); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stray_data1 = {12{4'd9}};
        stray_ack1 = 1'b1;
        @(negedge clk);
        stray_ack1 = 1'b0;
        @(negedge clk);
        tests++; if (rd_req1 !== 1'b0) begin fails++; $display("FAIL rst_stray_req: got %0b expected 0", rd_req1); end
        tests++; if (underrun1 !== 1'b0) begin fails++; $display("FAIL rst_stray_underrun: got %0b expected 0", underrun1); end
        do_frame();
        do_line(0);
        tests++; if (rd_req1 !== 1'b1) begin fails++; $display("FAIL rst_fsm_idle_req: got %0b expected 1", rd_req1); end
        do_line(4);
        tests++; if (col1[0] !== 4'd0) begin fails++; $display("FAIL rst_front_cleared: got %0d expected 0", col1[0]); end
        tests++; if (underrun1 !== 1'b1) begin fails++; $display("FAIL rst_underrun_after: got %0b expected 1", underrun1); end
        ack_en1 = 1'b1;
    endtask

    task automatic test_param();
        int bad;
        int fx;
        logic [2:0] e;
        do_frame();
        for (int l = 0; l < 50; l++) begin
            do_line(170);
            bad = 0;
            fx = -1;
            for (int x = 0; x < 170; x++) begin
                if (l >= 1 && x < 160) e = 3'(((l - 1) / 16 + x / 16) % 8);
                else e = 3'd0;
                if (col2[x] !== e || v2[x] !== 1'b1) begin
                    bad++;
                    if (fx < 0) fx = x;
                end
            end
            tests++;
            if (bad !== 0) begin
                fails++;
                $display("FAIL param_line%0d: %0d pixels wrong, first x=%0d got %0d valid %0b", l, bad, fx, col2[fx], v2[fx]);
            end
        end
        tests++; if (underrun2 !== 1'b0) begin fails++; $display("FAIL param_underrun: got %0b expected 0", underrun2); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        frame_start = 1'b0;
        line_start = 1'b0;
        pix_valid = 1'b0;
        grid_en = 1'b0;
        ack_en1 = 1'b1;
        stray_ack1 = 1'b0;
        stray_data1 = '0;
        test_reset();
        test_basic();
        test_grid();
        test_underrun();
        test_reset_mid_fetch();
        test_param();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
